sudoku_check_seq: RTL and testbench



---
 rtl/sudoku_pkg.sv | 35 +++
 rtl/sudoku_check_seq_if.sv | 40 ++++
 rtl/sudoku_addr_gen.sv | 36 +++
 rtl/sudoku_check_seq.sv | 155 +++++++++++++++
 tb/tb_sudoku_check_seq.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku game blocks: board geometry, group
// numbering used by the checker, and the state encodings of the game FSMs.
package sudoku_pkg;

    localparam int GRID     = 4;
    localparam int VAL_W    = 3;
    localparam int N_GROUPS = 12;

    localparam logic [3:0] GROUP_ROW_BASE = 4'd0;
    localparam logic [3:0] GROUP_COL_BASE = 4'd4;
    localparam logic [3:0] GROUP_BOX_BASE = 4'd8;
    localparam logic [3:0] LAST_GROUP     = 4'(N_GROUPS - 1);

    // Board checker sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } chk_state_t;

    // Main game FSM states.
    typedef enum logic [1:0] {
        GAME_IDLE  = 2'd0,
        GAME_PLAY  = 2'd1,
        GAME_CHECK = 2'd2,
        GAME_WIN   = 2'd3
    } game_state_t;

    // Linear board address of a cell.
    function automatic logic [3:0] cell_addr(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/sudoku_check_seq_if.sv
// Request, board-read and verdict signals between the game FSM / board
// memory side (master) and the board checker sequencer (slave).
interface sudoku_check_seq_if;
    import sudoku_pkg::*;

    logic             start;
    logic             rd_en;
    logic [3:0]       rd_addr;
    logic [VAL_W-1:0] rd_data;
    logic             busy;
    logic             done;
    logic             solved;
    logic [3:0]       err_group;
    logic             err_empty;

    modport master (
        output start,
        input  rd_en,
        input  rd_addr,
        output rd_data,
        input  busy,
        input  done,
        input  solved,
        input  err_group,
        input  err_empty
    );

    modport slave (
        input  start,
        output rd_en,
        output rd_addr,
        input  rd_data,
        output busy,
        output done,
        output solved,
        output err_group,
        output err_empty
    );

endinterface

// File: rtl/sudoku_addr_gen.sv
// Maps a constraint group g (0-3 rows, 4-7 cols, 8-11 boxes) and an index i
// within that group onto the board address row*4 + col.
module sudoku_addr_gen
    import sudoku_pkg::*;
(
    input  logic [3:0] g,
    input  logic [1:0] i,
    output logic [3:0] addr
);

    logic [1:0] rel;
    logic [1:0] row;
    logic [1:0] col;

    // Select row/column of the cell from the group kind and its offset.
    always_comb begin
        rel = '0;
        row = '0;
        col = '0;
        if (g < GROUP_COL_BASE) begin
            rel = 2'(g - GROUP_ROW_BASE);
            row = rel;
            col = i;
        end else if (g < GROUP_BOX_BASE) begin
            rel = 2'(g - GROUP_COL_BASE);
            row = i;
            col = rel;
        end else begin
            rel = 2'(g - GROUP_BOX_BASE);
            row = {rel[1], i[1]};
            col = {rel[0], i[0]};
        end
        addr = cell_addr(row, col);
    end

endmodule

// File: rtl/sudoku_check_seq.sv
// Board checker: on a start pulse, reads every cell of each of the 12
// constraint groups in turn and checks it against a per-group seen-mask.
// Stops at the first empty, out-of-range or duplicate value and reports the
// offending group; otherwise reports the board as solved.
module sudoku_check_seq #(
    parameter int GRID  = sudoku_pkg::GRID,
    parameter int VAL_W = sudoku_pkg::VAL_W
) (
    input logic               clka,
    input logic               restart,
    sudoku_check_seq_if.slave bus
);
    import sudoku_pkg::*;

    if (GRID != 4) begin : g_grid_check
        $error("sudoku_check_seq: only GRID=4 is supported");
    end
    if (VAL_W != sudoku_pkg::VAL_W) begin : g_val_w_check
        $error("sudoku_check_seq: VAL_W must match sudoku_pkg::VAL_W");
    end

    localparam logic [VAL_W-1:0] MAX_VAL = VAL_W'(GRID);

    chk_state_t      state;
    chk_state_t      state_nx;
    logic [3:0]      g;
    logic [1:0]      i;
    logic [3:0]      chk_g;
    logic [1:0]      chk_i;
    logic            chk_valid;
    logic [GRID-1:0] seen;
    logic [GRID-1:0] seen_base;
    logic [GRID-1:0] v_bit;
    logic            check_active;
    logic            cell_empty;
    logic            cell_err;
    logic            last_issue;
    logic [3:0]      gen_addr;

    sudoku_addr_gen u_addr_gen (
        .g    (g),
        .i    (i),
        .addr (gen_addr)
    );

    assign last_issue = (g == LAST_GROUP) && (i == 2'd3);

    // Judge the value returned for the read issued on the previous cycle.
    always_comb begin
        check_active = chk_valid && ((state == SCAN) || (state == DRAIN));
        seen_base    = (chk_i == 2'd0) ? '0 : seen;
        v_bit        = GRID'(1) << (bus.rd_data - VAL_W'(1));
        cell_empty   = (bus.rd_data == '0);
        cell_err     = check_active &&
                       (cell_empty || (bus.rd_data > MAX_VAL) || (|(seen_base & v_bit)));
    end

    // State register.
    always_ff @(posedge clka) begin
        if (restart) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and the read/status strobes derived from the state.
    always_comb begin
        state_nx    = state;
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = gen_addr;
                bus.busy    = 1'b1;
                if (cell_err) begin
                    state_nx = DONE;
                end else if (last_issue) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                bus.busy = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Group/index walk, read-to-check pipeline tag, and the seen-mask.
    always_ff @(posedge clka) begin
        if (restart) begin
            g         <= '0;
            i         <= '0;
            chk_g     <= '0;
            chk_i     <= '0;
            chk_valid <= 1'b0;
            seen      <= '0;
        end else begin
            chk_valid <= bus.rd_en;
            chk_g     <= g;
            chk_i     <= i;
            if ((state == IDLE) && bus.start) begin
                g <= '0;
                i <= '0;
            end else if (state == SCAN) begin
                if (i == 2'd3) begin
                    i <= '0;
                    g <= g + 4'd1;
                end else begin
                    i <= i + 2'd1;
                end
            end
            if (check_active && !cell_err) begin
                seen <= seen_base | v_bit;
            end
        end
    end

    // Verdict: cleared on an accepted start, set when the scan ends.
    always_ff @(posedge clka) begin
        if (restart) begin
            bus.solved    <= 1'b0;
            bus.err_group <= '0;
            bus.err_empty <= 1'b0;
        end else if ((state == IDLE) && bus.start) begin
            bus.solved    <= 1'b0;
            bus.err_group <= '0;
            bus.err_empty <= 1'b0;
        end else if (cell_err) begin
            bus.solved    <= 1'b0;
            bus.err_group <= chk_g;
            bus.err_empty <= cell_empty;
        end else if (state == DRAIN) begin
            bus.solved    <= 1'b1;
            bus.err_group <= '0;
            bus.err_empty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sudoku_check_seq.sv
// Testbench for the board checker: directed boards from the test plan,
// start/restart corner cases and randomized boards judged by a reference
// model that walks rows, columns and boxes directly over the board array.
module tb_sudoku_check_seq;
    import sudoku_pkg::*;

    logic clka = 1'b0;
    logic restart;

    always #5 clka = ~clka;

    sudoku_check_seq_if bus ();

    sudoku_check_seq #(.GRID(GRID), .VAL_W(VAL_W)) dut (
        .clka    (clka),
        .restart (restart),
        .bus     (bus)
    );

    logic [2:0] board [16];
    int         flat_addr [48];
    int         errors = 0;
    int         checks = 0;

    int         obs_done_cycle, obs_done_count;
    int         obs_busy_count, obs_busy_last;
    int         obs_rd_first, obs_rd_last, obs_rd_count;
    logic       obs_solved, obs_err_empty, obs_solved_c1, obs_solved_end;
    logic [3:0] obs_err_group, obs_group_c1;
    logic [3:0] obs_addr [$];

    // Board memory: data appears one cycle after the read strobe.
    always @(posedge clka) begin
        if (bus.rd_en) bus.rd_data <= board[bus.rd_addr];
    end

    task automatic build_groups();
        int n = 0;
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) begin flat_addr[n] = r*4 + c; n++; end
        for (int c = 0; c < 4; c++) for (int r = 0; r < 4; r++) begin flat_addr[n] = r*4 + c; n++; end
        for (int br = 0; br < 2; br++) for (int bc = 0; bc < 2; bc++)
            for (int dr = 0; dr < 2; dr++) for (int dc = 0; dc < 2; dc++) begin
                flat_addr[n] = (2*br + dr)*4 + 2*bc + dc;
                n++;
            end
    endtask

    task automatic load_rows(input int r0, input int r1, input int r2, input int r3);
        int rows [4];
        int d;
        rows = '{r0, r1, r2, r3};
        for (int r = 0; r < 4; r++) begin
            d = rows[r];
            for (int c = 3; c >= 0; c--) begin
                board[r*4 + c] = 3'(d % 10);
                d = d / 10;
            end
        end
    endtask

    // Reference: index (0..47) of the first bad check in walk order, or -1.
    task automatic model_scan(output int fail_idx, output logic fail_empty);
        bit [7:0] seen;
        int v;
        fail_idx = -1;
        fail_empty = 1'b0;
        seen = '0;
        for (int n = 0; n < 48 && fail_idx < 0; n++) begin
            if (n % 4 == 0) seen = '0;
            v = int'(board[flat_addr[n]]);
            if (v == 0) begin fail_idx = n; fail_empty = 1'b1; end
            else if (v > 4) fail_idx = n;
            else if (seen[v]) fail_idx = n;
            else seen[v] = 1'b1;
        end
    endtask

    // Start a check at cycle 0 and record outputs for n_cycles cycles.
    task automatic observe(input int n_cycles, input int start2_at, input int restart_at);
        obs_done_cycle = -1; obs_done_count = 0; obs_busy_count = 0; obs_busy_last = -1;
        obs_rd_first = -1; obs_rd_last = -1; obs_rd_count = 0;
        obs_solved = 1'bx; obs_err_group = 'x; obs_err_empty = 1'bx;
        obs_addr.delete();
        @(negedge clka);
        bus.start = 1'b1;
        restart = 1'b0;
        for (int c = 1; c <= n_cycles; c++) begin
            @(negedge clka);
            bus.start = (c == start2_at);
            restart = (c == restart_at);
            if (bus.rd_en) begin
                if (obs_rd_first < 0) obs_rd_first = c;
                obs_rd_last = c;
                obs_rd_count++;
                obs_addr.push_back(bus.rd_addr);
            end
            if (bus.busy) begin obs_busy_count++; obs_busy_last = c; end
            if (bus.done) begin
                obs_done_count++;
                if (obs_done_cycle < 0) begin
                    obs_done_cycle = c;
                    obs_solved = bus.solved;
                    obs_err_group = bus.err_group;
                    obs_err_empty = bus.err_empty;
                end
            end
            if (c == 1) begin obs_solved_c1 = bus.solved; obs_group_c1 = bus.err_group; end
        end
        bus.start = 1'b0;
        restart = 1'b0;
        obs_solved_end = bus.solved;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        restart = 1'b1;
        repeat (3) @(negedge clka);
        checks++; if (bus.rd_en !== 1'b0) begin errors++; $display("[TB] FAIL reset rd_en: got %0b expected 0", bus.rd_en); end
        checks++; if (bus.rd_addr !== 4'd0) begin errors++; $display("[TB] FAIL reset rd_addr: got %0d expected 0", bus.rd_addr); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %0b expected 0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin errors++; $display("[TB] FAIL reset done: got %0b expected 0", bus.done); end
        checks++; if (bus.solved !== 1'b0) begin errors++; $display("[TB] FAIL reset solved: got %0b expected 0", bus.solved); end
        checks++; if (bus.err_group !== 4'd0) begin errors++; $display("[TB] FAIL reset err_group: got %0d expected 0", bus.err_group); end
        checks++; if (bus.err_empty !== 1'b0) begin errors++; $display("[TB] FAIL reset err_empty: got %0b expected 0", bus.err_empty); end
        restart = 1'b0;
        @(negedge clka);
    endtask

    task automatic test_directed();
        int exp_done [4] = '{50, 8, 37, 3};
        int exp_grp [4]  = '{0, 1, 8, 0};
        int exp_emp [4]  = '{0, 1, 0, 0};
        int exp_sol [4]  = '{1, 0, 0, 0};
        int exp_last;
        for (int t = 0; t < 4; t++) begin
            if (t == 2) load_rows(1234, 2341, 3412, 4123);
            else        load_rows(1234, 3412, 2143, 4321);
            if (t == 1) board[5] = 3'd0;
            if (t == 3) board[0] = 3'd6;
            observe(55, -1, -1);
            exp_last = (exp_sol[t] == 1) ? 48 : exp_done[t] - 1;
            checks++; if (obs_done_cycle !== exp_done[t]) begin errors++; $display("[TB] FAIL directed%0d done_cycle: got %0d expected %0d", t, obs_done_cycle, exp_done[t]); end
            checks++; if (obs_done_count !== 1) begin errors++; $display("[TB] FAIL directed%0d done_count: got %0d expected 1", t, obs_done_count); end
            checks++; if (obs_solved !== 1'(exp_sol[t])) begin errors++; $display("[TB] FAIL directed%0d solved: got %0b expected %0d", t, obs_solved, exp_sol[t]); end
            checks++; if (obs_err_group !== 4'(exp_grp[t])) begin errors++; $display("[TB] FAIL directed%0d err_group: got %0d expected %0d", t, obs_err_group, exp_grp[t]); end
            checks++; if (obs_err_empty !== 1'(exp_emp[t])) begin errors++; $display("[TB] FAIL directed%0d err_empty: got %0b expected %0d", t, obs_err_empty, exp_emp[t]); end
            checks++; if (obs_rd_first !== 1 || obs_rd_last !== exp_last || obs_rd_count !== exp_last) begin errors++; $display("[TB] FAIL directed%0d rd_en window: got %0d..%0d (%0d) expected 1..%0d", t, obs_rd_first, obs_rd_last, obs_rd_count, exp_last); end
            checks++; if (obs_busy_count !== exp_done[t] - 1 || obs_busy_last !== exp_done[t] - 1) begin errors++; $display("[TB] FAIL directed%0d busy: got %0d cycles last %0d expected %0d", t, obs_busy_count, obs_busy_last, exp_done[t] - 1); end
            checks++; if (obs_solved_end !== 1'(exp_sol[t])) begin errors++; $display("[TB] FAIL directed%0d solved_held: got %0b expected %0d", t, obs_solved_end, exp_sol[t]); end
            for (int j = 0; j < obs_addr.size() && j < 48; j++) begin
                checks++;
                if (obs_addr[j] !== 4'(flat_addr[j])) begin errors++; $display("[TB] FAIL directed%0d rd_addr cycle %0d: got %0d expected %0d", t, j + 1, obs_addr[j], flat_addr[j]); end
            end
        end
    endtask

    task automatic test_ignored_start();
        load_rows(1234, 3412, 2143, 4321);
        observe(60, 10, -1);
        checks++; if (obs_done_cycle !== 50) begin errors++; $display("[TB] FAIL ignored_start done_cycle: got %0d expected 50", obs_done_cycle); end
        checks++; if (obs_done_count !== 1) begin errors++; $display("[TB] FAIL ignored_start done_count: got %0d expected 1", obs_done_count); end
        checks++; if (obs_rd_count !== 48) begin errors++; $display("[TB] FAIL ignored_start rd_count: got %0d expected 48", obs_rd_count); end
        checks++; if (obs_solved !== 1'b1) begin errors++; $display("[TB] FAIL ignored_start solved: got %0b expected 1", obs_solved); end
    endtask

    task automatic test_restart_mid();
        load_rows(1234, 3412, 2143, 4321);
        board[5] = 3'd0;
        observe(10, -1, -1);
        restart = 1'b1;
        @(negedge clka);
        restart = 1'b0;
        checks++; if (bus.err_group !== 4'd0 || bus.err_empty !== 1'b0) begin errors++; $display("[TB] FAIL restart verdict_clear: got group %0d empty %0b expected 0 0", bus.err_group, bus.err_empty); end
        board[5] = 3'd4;
        observe(80, 25, 20);
        checks++; if (obs_done_cycle !== 75) begin errors++; $display("[TB] FAIL restart done_cycle: got %0d expected 75", obs_done_cycle); end
        checks++; if (obs_done_count !== 1) begin errors++; $display("[TB] FAIL restart done_count: got %0d expected 1", obs_done_count); end
        checks++; if (obs_busy_count !== 69 || obs_busy_last !== 74) begin errors++; $display("[TB] FAIL restart busy: got %0d cycles last %0d expected 69 last 74", obs_busy_count, obs_busy_last); end
        checks++; if (obs_rd_count !== 68 || obs_rd_last !== 73) begin errors++; $display("[TB] FAIL restart rd_en: got %0d cycles last %0d expected 68 last 73", obs_rd_count, obs_rd_last); end
        for (int j = 0; j < obs_addr.size() && j < 68; j++) begin
            checks++;
            if (obs_addr[j] !== 4'(flat_addr[(j < 20) ? j : j - 20])) begin errors++; $display("[TB] FAIL restart rd_addr index %0d: got %0d expected %0d", j, obs_addr[j], flat_addr[(j < 20) ? j : j - 20]); end
        end
        checks++; if (obs_solved !== 1'b1) begin errors++; $display("[TB] FAIL restart solved: got %0b expected 1", obs_solved); end
    endtask

    task automatic test_back_to_back();
        load_rows(1234, 3412, 2143, 4321);
        board[5] = 3'd0;
        observe(8, -1, -1);
        checks++; if (obs_err_group !== 4'd1) begin errors++; $display("[TB] FAIL b2b first err_group: got %0d expected 1", obs_err_group); end
        board[5] = 3'd4;
        observe(50, -1, -1);
        checks++; if (obs_group_c1 !== 4'd0) begin errors++; $display("[TB] FAIL b2b cleared err_group: got %0d expected 0", obs_group_c1); end
        checks++; if (obs_done_cycle !== 50 || obs_solved !== 1'b1) begin errors++; $display("[TB] FAIL b2b second verdict: got done %0d solved %0b expected 50 1", obs_done_cycle, obs_solved); end
        board[0] = 3'd6;
        observe(5, -1, -1);
        checks++; if (obs_solved_c1 !== 1'b0) begin errors++; $display("[TB] FAIL b2b cleared solved: got %0b expected 0", obs_solved_c1); end
        checks++; if (obs_done_cycle !== 3 || obs_err_group !== 4'd0 || obs_err_empty !== 1'b0) begin errors++; $display("[TB] FAIL b2b third verdict: got done %0d group %0d empty %0b expected 3 0 0", obs_done_cycle, obs_err_group, obs_err_empty); end
    endtask

    task automatic test_random();
        int perm [5];
        int tmp, k, a, fail_idx, exp_done, exp_last;
        logic fail_empty;
        logic [2:0] row_buf;
        for (int it = 0; it < 16; it++) begin
            load_rows(1234, 3412, 2143, 4321);
            perm = '{0, 1, 2, 3, 4};
            for (int s = 4; s > 1; s--) begin
                k = $urandom_range(1, s);
                tmp = perm[s]; perm[s] = perm[k]; perm[k] = tmp;
            end
            for (int n = 0; n < 16; n++) board[n] = 3'(perm[board[n]]);
            if ($urandom_range(0, 1) == 1)
                for (int c = 0; c < 4; c++) begin row_buf = board[c]; board[c] = board[4 + c]; board[4 + c] = row_buf; end
            if ($urandom_range(0, 1) == 1)
                for (int r = 0; r < 4; r++) begin row_buf = board[r*4 + 2]; board[r*4 + 2] = board[r*4 + 3]; board[r*4 + 3] = row_buf; end
            a = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                1: board[a] = 3'd0;
                2: board[a] = 3'($urandom_range(5, 7));
                3: board[a] = board[$urandom_range(0, 15)];
                default: ;
            endcase
            model_scan(fail_idx, fail_empty);
            exp_done = (fail_idx < 0) ? 50 : fail_idx + 3;
            exp_last = (fail_idx < 0) ? 48 : ((fail_idx + 2 > 48) ? 48 : fail_idx + 2);
            observe(52, -1, -1);
            checks++; if (obs_done_cycle !== exp_done || obs_done_count !== 1) begin errors++; $display("[TB] FAIL random%0d done: got cycle %0d count %0d expected cycle %0d count 1", it, obs_done_cycle, obs_done_count, exp_done); end
            checks++; if (obs_solved !== (fail_idx < 0)) begin errors++; $display("[TB] FAIL random%0d solved: got %0b expected %0b", it, obs_solved, fail_idx < 0); end
            checks++; if (obs_err_group !== ((fail_idx < 0) ? 4'd0 : 4'(fail_idx / 4))) begin errors++; $display("[TB] FAIL random%0d err_group: got %0d expected %0d", it, obs_err_group, (fail_idx < 0) ? 0 : fail_idx / 4); end
            checks++; if (obs_err_empty !== fail_empty) begin errors++; $display("[TB] FAIL random%0d err_empty: got %0b expected %0b", it, obs_err_empty, fail_empty); end
            checks++; if (obs_rd_last !== exp_last || obs_rd_count !== exp_last) begin errors++; $display("[TB] FAIL random%0d rd_en: got last %0d count %0d expected %0d", it, obs_rd_last, obs_rd_count, exp_last); end
            for (int j = 0; j < obs_addr.size() && j < 48; j++) begin
                checks++;
                if (obs_addr[j] !== 4'(flat_addr[j])) begin errors++; $display("[TB] FAIL random%0d rd_addr cycle %0d: got %0d expected %0d", it, j + 1, obs_addr[j], flat_addr[j]); end
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        restart = 1'b1;
        build_groups();
        test_reset();
        test_directed();
        test_ignored_start();
        test_restart_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
